// File: rtl/mem_stage.sv
// Memory-access stage: latches the instruction from execute, extracts load data from the
// synchronous data SRAM, and keeps that data across write-back stalls.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es2ms_valid,
  output logic         ms_allowin,
  input  logic [123:0] es2ms_bus,
  input  logic [38:0]  es_rf_zip,
  input  logic [31:0]  data_sram_rdata,
  input  logic         ws_allowin,
  output logic         ms2ws_valid,
  output logic [117:0] ms2ws_bus,
  output logic [38:0]  ms_rf_zip,
  output logic [38:0]  ms_fwd_zip,
  output logic         ms_ex,
  input  logic         wb_ex,
  input  logic         ertn_flush
);

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic [4:0]  ld_op;       // {w, hu, h, bu, b}
    logic [78:0] csr_zip;
    logic [5:0]  exc_flags;   // {int, brk, ine, adef, sys, ertn}
    logic        ale;
  } es_bus_t;

  typedef struct packed {
    logic        csr_re;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_zip_t;

  logic        ms_valid;
  logic        ms_ready_go;
  logic        flush;
  logic        accept;
  es_bus_t     bus_r;
  rf_zip_t     rf_r;
  logic        first_cycle;
  logic [31:0] rdata_buf;
  logic [31:0] rdata_sel;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [1:0]  addr_low;
  logic [31:0] ld_data;
  logic [31:0] final_wdata;
  logic        ms_has_exc;
  logic        rf_we_eff;
  logic        ld_pending;

  assign ms_ready_go = 1'b1;
  assign flush       = wb_ex | ertn_flush;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go;
  assign accept      = es2ms_valid & ms_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      bus_r       <= '0;
      rf_r        <= '0;
      first_cycle <= 1'b0;
      rdata_buf   <= '0;
    end else begin
      if (flush)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es2ms_valid;
      if (accept) begin
        bus_r <= es2ms_bus;
        rf_r  <= es_rf_zip;
      end
      first_cycle <= accept;
      // SRAM data is only valid in the first resident cycle; keep it for stalls
      if (ms_valid & first_cycle & bus_r.res_from_mem)
        rdata_buf <= data_sram_rdata;
    end
  end

  assign rdata_sel = first_cycle ? data_sram_rdata : rdata_buf;
  assign addr_low  = rf_r.rf_wdata[1:0];
  assign shifted   = rdata_sel >> {addr_low, 3'b000};
  assign half      = addr_low[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  always_comb begin
    ld_data = rdata_sel;
    if (bus_r.ld_op[0])      ld_data = {{24{shifted[7]}}, shifted[7:0]};
    else if (bus_r.ld_op[1]) ld_data = {24'b0, shifted[7:0]};
    else if (bus_r.ld_op[2]) ld_data = {{16{half[15]}}, half};
    else if (bus_r.ld_op[3]) ld_data = {16'b0, half};
  end

  assign final_wdata = bus_r.res_from_mem ? ld_data : rf_r.rf_wdata;
  assign ms_has_exc  = ms_valid & ((|bus_r.exc_flags) | bus_r.ale);
  assign rf_we_eff   = rf_r.rf_we & ms_valid & ~ms_has_exc;
  assign ld_pending  = ms_valid & bus_r.res_from_mem & ~ms_has_exc;

  assign ms_ex      = ms_has_exc;
  assign ms2ws_bus  = {bus_r.pc, bus_r.csr_zip, bus_r.exc_flags, bus_r.ale};
  assign ms_rf_zip  = {rf_r.csr_re, rf_we_eff, rf_r.rf_waddr, final_wdata};
  assign ms_fwd_zip = {ld_pending, rf_we_eff, rf_r.rf_waddr, final_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected results, a negedge monitor
// compares whenever the stage offers an instruction to write-back.
module tb_mem_stage;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         es2ms_valid = 1'b0;
  logic         ws_allowin = 1'b1;
  logic         wb_ex = 1'b0;
  logic         ertn_flush = 1'b0;
  logic [123:0] es2ms_bus = '0;
  logic [38:0]  es_rf_zip = '0;
  logic [31:0]  data_sram_rdata = '0;
  logic         ms_allowin, ms2ws_valid, ms_ex;
  logic [117:0] ms2ws_bus;
  logic [38:0]  ms_rf_zip, ms_fwd_zip;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es2ms_bus(es2ms_bus), .es_rf_zip(es_rf_zip), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid), .ms2ws_bus(ms2ws_bus),
    .ms_rf_zip(ms_rf_zip), .ms_fwd_zip(ms_fwd_zip), .ms_ex(ms_ex),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [117:0] bus;
    logic [38:0]  rf;
    logic [38:0]  fwd;
    logic         ex;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  localparam logic [4:0] LD_B = 5'b00001, LD_BU = 5'b00010, LD_H = 5'b00100,
                         LD_HU = 5'b01000, LD_W = 5'b10000, NOLD = 5'b00000;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ms2ws_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("ms2ws_bus", ms2ws_bus, q[0].bus);
        chk("ms_rf_zip", ms_rf_zip, q[0].rf);
        chk("ms_fwd_zip", ms_fwd_zip, q[0].fwd);
        chk("ms_ex", ms_ex, q[0].ex);
        if (ws_allowin) void'(q.pop_front());
      end
    end
  end

  // Builds the expected record and the driven bus for one instruction (rf_we always 1).
  task automatic prep(input logic [31:0] pc, input logic [4:0] ld, input logic [5:0] exc,
                      input logic ale, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] exp_wd);
    exp_t e;
    logic hx, pend;
    logic [78:0] csr;
    csr  = {47'h0, ~pc};
    hx   = (|exc) | ale;
    pend = (|ld) & ~hx;
    e.bus = {pc, csr, exc, ale};
    e.rf  = {1'b0, ~hx, wa, exp_wd};
    e.fwd = {pend, ~hx, wa, exp_wd};
    e.ex  = hx;
    q.push_back(e);
    es2ms_valid = 1'b1;
    es2ms_bus   = {pc, |ld, ld, csr, exc, ale};
    es_rf_zip   = {1'b0, 1'b1, wa, wd};
    data_sram_rdata = 32'h5A5A5A5A;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] ld, input logic [5:0] exc,
                      input logic ale, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] exp_wd, input int stall);
    ws_allowin = (stall == 0);
    prep(pc, ld, exc, ale, wa, wd, exp_wd);
    @(posedge clk); #1;
    chk("valid_after_accept", ms2ws_valid, 1);
    es2ms_valid = 1'b0; es2ms_bus = '0; es_rf_zip = '0;
    data_sram_rdata = rd;
    repeat (stall) begin
      @(posedge clk); #1;
      data_sram_rdata = 32'hDEADBEEF;
    end
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    data_sram_rdata = 32'h5A5A5A5A;
  endtask

  task automatic flush_test(input logic use_ertn);
    ws_allowin = 1'b1;
    prep(32'h0000_3000, LD_W, 6'b0, 1'b0, 5'd9, 32'h0000_3000, 32'h01020304);
    @(posedge clk); #1;
    data_sram_rdata = 32'h01020304;
    es2ms_bus = {32'h0000_4000, 1'b0, NOLD, 79'h0, 6'b0, 1'b0};
    es_rf_zip = {1'b0, 1'b1, 5'd3, 32'h77};
    es2ms_valid = 1'b1;
    wb_ex = ~use_ertn; ertn_flush = use_ertn;
    @(posedge clk); #1;
    wb_ex = 1'b0; ertn_flush = 1'b0; es2ms_valid = 1'b0;
    es2ms_bus = '0; es_rf_zip = '0;
    @(negedge clk);
    chk("flush_ms2ws_valid", ms2ws_valid, 0);
    chk("flush_rf_we_eff", ms_rf_zip[37], 0);
    chk("flush_ld_pending", ms_fwd_zip[38], 0);
    chk("flush_allowin", ms_allowin, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, ms2ws_valid, 0);
    chk({tag, "_allowin"}, ms_allowin, 1);
    chk({tag, "_bus"}, ms2ws_bus, 0);
    chk({tag, "_rf_zip"}, ms_rf_zip, 0);
    chk({tag, "_fwd_zip"}, ms_fwd_zip, 0);
    chk({tag, "_ex"}, ms_ex, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    // pc, ld_op, exc, ale, waddr, wdata(addr), rdata, expected wdata, stall cycles
    send(32'h100, LD_B,  6'b0, 1'b0, 5'd1, 32'h1003, 32'h80123456, 32'hFFFFFF80, 0);
    send(32'h104, LD_HU, 6'b0, 1'b0, 5'd2, 32'h1002, 32'hBEEF1234, 32'h0000BEEF, 0);
    send(32'h108, LD_H,  6'b0, 1'b0, 5'd3, 32'h1002, 32'hBEEF1234, 32'hFFFFBEEF, 0);
    send(32'h10C, LD_W,  6'b0, 1'b0, 5'd4, 32'h1000, 32'hBEEF1234, 32'hBEEF1234, 0);
    send(32'h110, LD_BU, 6'b0, 1'b0, 5'd6, 32'h1001, 32'h0000A500, 32'h000000A5, 0);
    send(32'h114, LD_H,  6'b0, 1'b0, 5'd7, 32'h1000, 32'h12347FFF, 32'h00007FFF, 0);
    send(32'h118, NOLD,  6'b0, 1'b0, 5'd5, 32'h123,  32'hFFFFFFFF, 32'h00000123, 0);
    send(32'h11C, LD_W,  6'b0, 1'b0, 5'd8, 32'h2000, 32'hCAFEF00D, 32'hCAFEF00D, 3);
    send(32'h120, LD_B,  6'b0, 1'b0, 5'd10, 32'h2002, 32'h00FE0000, 32'hFFFFFFFE, 2);
    send(32'h124, LD_W,  6'b0, 1'b1, 5'd11, 32'h1000, 32'h11112222, 32'h11112222, 0);
    send(32'h128, NOLD,  6'b000010, 1'b0, 5'd12, 32'h55, 32'h0, 32'h00000055, 0);
    chk("drained", q.size(), 0);

    flush_test(1'b0);
    flush_test(1'b1);
    chk("drained_flush", q.size(), 0);

    // reset while stalled drops the held instruction
    ws_allowin = 1'b0;
    prep(32'h200, LD_W, 6'b0, 1'b0, 5'd13, 32'h5000, 32'h0BADF00D);
    @(posedge clk); #1;
    es2ms_valid = 1'b0; es2ms_bus = '0; es_rf_zip = '0;
    data_sram_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    q.delete();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    @(posedge clk); #1;
    send(32'h204, LD_HU, 6'b0, 1'b0, 5'd14, 32'h6000, 32'h9876ABCD, 32'h0000ABCD, 1);
    chk("drained_final", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
